ascon_stream_seq: RTL and testbench

Host-side sequencer for the Ascon encryption subsystem, sitting on the opposite end of the Ascon wrapper's FIFO interface. It reads associated-data (AD) and plaintext (PT) blocks from a single-port scratch memory and pushes them into the wrapper's AD/PT FIFOs. It pops ciphertext (CT) blocks from the CT FIFO and writes them back to memory, then latches the 128-bit tag. This lets one start command run a full encryption without per-block software involvement.

---
 rtl/ascon_pack.sv | 16 +
 rtl/ascon_stream_seq_if.sv | 38 +++
 rtl/ascon_stream_seq.sv | 127 ++++++++++++
 tb/tb_ascon_stream_seq.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// Shared types for the Ascon subsystem: block-sized words and the host
// sequencer state encoding.
package ascon_pack;
  localparam int BLOCK_WIDTH = 64;

  typedef logic [BLOCK_WIDTH-1:0] u64_t;
  typedef logic [127:0]           u128_t;

  typedef enum logic [2:0] {
    SEQ_IDLE     = 3'd0,
    SEQ_START    = 3'd1,
    SEQ_XFER     = 3'd2,
    SEQ_WAIT_TAG = 3'd3,
    SEQ_DONE     = 3'd4
  } seq_state_t;
endpackage

// File: rtl/ascon_stream_seq_if.sv
// Scratch-memory port plus the wrapper's AD/PT/CT FIFO and status signals,
// seen from the sequencer (master) and from the memory/wrapper side (slave).
interface ascon_stream_seq_if #(
  parameter int MEM_AW = 8
);
  logic [MEM_AW-1:0]  mem_addr_o;
  logic               mem_rd_o;
  logic               mem_wr_o;
  ascon_pack::u64_t   mem_wdata_o;
  ascon_pack::u64_t   mem_rdata_i;
  logic               core_ready_i;
  logic               tag_valid_i;
  ascon_pack::u128_t  tag_i;
  logic               core_start_o;
  logic               ad_push_o;
  logic               pt_push_o;
  ascon_pack::u64_t   ad_o;
  ascon_pack::u64_t   pt_o;
  logic               ad_full_i;
  logic               pt_full_i;
  logic               ct_pop_o;
  ascon_pack::u64_t   ct_i;
  logic               ct_empty_i;

  modport master (
    output mem_addr_o, mem_rd_o, mem_wr_o, mem_wdata_o, core_start_o,
           ad_push_o, pt_push_o, ad_o, pt_o, ct_pop_o,
    input  mem_rdata_i, core_ready_i, tag_valid_i, tag_i,
           ad_full_i, pt_full_i, ct_i, ct_empty_i
  );

  modport slave (
    input  mem_addr_o, mem_rd_o, mem_wr_o, mem_wdata_o, core_start_o,
           ad_push_o, pt_push_o, ad_o, pt_o, ct_pop_o,
    output mem_rdata_i, core_ready_i, tag_valid_i, tag_i,
           ad_full_i, pt_full_i, ct_i, ct_empty_i
  );
endinterface

// File: rtl/ascon_stream_seq.sv
// Host sequencer: streams AD/PT blocks from scratch memory into the Ascon
// wrapper FIFOs, drains CT back to memory and latches the final tag.
module ascon_stream_seq
  import ascon_pack::*;
#(
  parameter int DATA_AW = 7,
  parameter int MEM_AW  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go_i,
  input  logic [MEM_AW-1:0]  ad_base_i,
  input  logic [MEM_AW-1:0]  pt_base_i,
  input  logic [MEM_AW-1:0]  ct_base_i,
  input  logic [DATA_AW-1:0] ad_words_i,
  input  logic [DATA_AW-1:0] pt_words_i,
  output logic               busy_o,
  output logic               done_o,
  output u128_t              tag_o,
  ascon_stream_seq_if.master bus
);
  localparam logic [2:0] S_IDLE  = SEQ_IDLE;
  localparam logic [2:0] S_START = SEQ_START;
  localparam logic [2:0] S_XFER  = SEQ_XFER;
  localparam logic [2:0] S_WAIT  = SEQ_WAIT_TAG;
  localparam logic [2:0] S_DONE  = SEQ_DONE;

  logic [2:0]         state, state_nxt;
  logic [MEM_AW-1:0]  ad_base, pt_base, ct_base;
  logic [DATA_AW-1:0] ad_words, pt_words, ad_cnt, pt_cnt, ct_cnt;
  logic               rd_pend, rd_pt, tag_seen;
  logic               accept, in_xfer, ct_go, ad_go, pt_go, xfer_fin;
  logic               ad_push, pt_push, tag_window;

  // ---------------- control ----------------
  assign accept     = (state == S_IDLE) & go_i & bus.core_ready_i;
  assign in_xfer    = (state == S_XFER);
  assign tag_window = (state == S_START) | in_xfer | (state == S_WAIT);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_START;
      S_START: state_nxt = S_XFER;
      S_XFER:  if (xfer_fin) state_nxt = S_WAIT;
      S_WAIT:  if (tag_seen | bus.tag_valid_i) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  assign busy_o           = (state != S_IDLE);
  assign done_o           = (state == S_DONE);
  assign bus.core_start_o = (state == S_START);

  // ---------------- datapath ----------------
  // CT drain outranks reads so the wrapper's CT FIFO never stalls the core;
  // reads are single-outstanding, which is what keeps pushes off full FIFOs.
  assign ct_go    = in_xfer & ~bus.ct_empty_i & (ct_cnt < pt_words);
  assign ad_go    = in_xfer & ~ct_go & ~rd_pend & (ad_cnt < ad_words) & ~bus.ad_full_i;
  assign pt_go    = in_xfer & ~ct_go & ~rd_pend & (ad_cnt == ad_words)
                  & (pt_cnt < pt_words) & ~bus.pt_full_i;
  assign xfer_fin = in_xfer & ~rd_pend & (ad_cnt == ad_words)
                  & (pt_cnt == pt_words) & (ct_cnt == pt_words);

  assign ad_push = rd_pend & ~rd_pt;
  assign pt_push = rd_pend & rd_pt;

  always_comb begin
    bus.mem_addr_o = '0;
    if (ct_go)      bus.mem_addr_o = ct_base + MEM_AW'(ct_cnt);
    else if (ad_go) bus.mem_addr_o = ad_base + MEM_AW'(ad_cnt);
    else if (pt_go) bus.mem_addr_o = pt_base + MEM_AW'(pt_cnt);
  end

  assign bus.mem_rd_o    = ad_go | pt_go;
  assign bus.mem_wr_o    = ct_go;
  assign bus.ct_pop_o    = ct_go;
  assign bus.mem_wdata_o = ct_go ? bus.ct_i : '0;
  assign bus.ad_push_o   = ad_push;
  assign bus.pt_push_o   = pt_push;
  assign bus.ad_o        = ad_push ? bus.mem_rdata_i : '0;
  assign bus.pt_o        = pt_push ? bus.mem_rdata_i : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ad_base  <= '0;
      pt_base  <= '0;
      ct_base  <= '0;
      ad_words <= '0;
      pt_words <= '0;
      ad_cnt   <= '0;
      pt_cnt   <= '0;
      ct_cnt   <= '0;
      rd_pend  <= 1'b0;
      rd_pt    <= 1'b0;
      tag_seen <= 1'b0;
      tag_o    <= '0;
    end else begin
      if (accept) begin
        ad_base  <= ad_base_i;
        pt_base  <= pt_base_i;
        ct_base  <= ct_base_i;
        ad_words <= ad_words_i;
        pt_words <= pt_words_i;
        ad_cnt   <= '0;
        pt_cnt   <= '0;
        ct_cnt   <= '0;
        tag_seen <= 1'b0;
      end
      rd_pend <= ad_go | pt_go;
      rd_pt   <= pt_go;
      if (ad_push) ad_cnt <= ad_cnt + DATA_AW'(1);
      if (pt_push) pt_cnt <= pt_cnt + DATA_AW'(1);
      if (ct_go)   ct_cnt <= ct_cnt + DATA_AW'(1);
      if (bus.tag_valid_i & tag_window) begin
        tag_o    <= bus.tag_i;
        tag_seen <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ascon_stream_seq.sv
// Bench for ascon_stream_seq: memory + FIFO model around the sequencer, with
// queued expected addresses/data compared as the sequencer produces them.
module tb_ascon_stream_seq;
  import ascon_pack::*;

  localparam int   DATA_AW = 7;
  localparam int   MEM_AW  = 8;
  localparam u64_t CT_KEY  = 64'hA5C3_0F1E_5A69_3C87;

  logic               clk = 1'b0;
  logic               rst;
  logic               go_i;
  logic [MEM_AW-1:0]  ad_base_i, pt_base_i, ct_base_i;
  logic [DATA_AW-1:0] ad_words_i, pt_words_i;
  logic               busy_o, done_o;
  u128_t              tag_o;

  ascon_stream_seq_if #(.MEM_AW(MEM_AW)) bus ();

  ascon_stream_seq #(.DATA_AW(DATA_AW), .MEM_AW(MEM_AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .go_i       (go_i),
    .ad_base_i  (ad_base_i),
    .pt_base_i  (pt_base_i),
    .ct_base_i  (ct_base_i),
    .ad_words_i (ad_words_i),
    .pt_words_i (pt_words_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .tag_o      (tag_o),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ad_base, pt_base, ct_base;
    int         ad_n, pt_n;
    bit         preload;    // CT FIFO filled before start (one spare entry)
    bit         early_tag;  // tag arrives during XFER instead of WAIT_TAG
    int         full_hold;  // cycles of ad_full_i after start
    u128_t      tag;
    int         exp_rd, exp_wr;
  } vec_t;

  vec_t vecs[7];

  u64_t       mem [256];
  u64_t       ct_q[$], exp_ad[$], exp_pt[$], exp_wr_data[$];
  logic [7:0] exp_rd[$], exp_wr_addr[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_rd, n_start, n_done, wr_done, n_push, gen_k, bp_viol;
  int start_cyc, done_cyc, tag_cyc, last_evt_cyc, last_rd_cyc, first_rd_cyc, go_cyc;
  int cur_ad_n, cur_pt_n;
  bit started, gen_ct;
  logic [7:0] cur_ct_base;
  bit s_rd, s_wr, s_pop, s_ptpush;
  logic [7:0] s_rd_addr, s_wr_addr;
  u64_t s_wr_data, s_pt_data;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic u64_t rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic refresh_ct();
    bus.ct_empty_i = (ct_q.size() == 0);
    bus.ct_i       = (ct_q.size() != 0) ? ct_q[0] : rnd64();
  endtask

  // Observe one cycle of DUT activity (called mid-cycle, away from the edge).
  task automatic monitor();
    cyc++;
    chk("rd_wr_excl", 128'(bus.mem_rd_o & bus.mem_wr_o), 128'(0));
    if (started && wr_done < cur_pt_n && !bus.ct_empty_i)
      chk("ct_priority", 128'(bus.mem_wr_o), 128'(1));
    if (bus.mem_rd_o) begin
      if (bus.ad_full_i && n_rd < cur_ad_n) bp_viol++;
      chk("rd_outstanding", 128'(last_rd_cyc == cyc - 1), 128'(0));
      if (exp_rd.size() != 0) chk("rd_addr", 128'(bus.mem_addr_o), 128'(exp_rd.pop_front()));
      if (n_rd == 0) first_rd_cyc = cyc;
      n_rd++;
      last_rd_cyc  = cyc;
      last_evt_cyc = cyc;
      s_rd         = 1'b1;
      s_rd_addr    = bus.mem_addr_o;
    end
    if (bus.mem_wr_o) begin
      chk("wr_pop", 128'(bus.ct_pop_o), 128'(1));
      if (exp_wr_addr.size() != 0) begin
        chk("wr_addr", 128'(bus.mem_addr_o), 128'(exp_wr_addr.pop_front()));
        chk("wr_data", 128'(bus.mem_wdata_o), 128'(exp_wr_data.pop_front()));
      end
      wr_done++;
      last_evt_cyc = cyc;
      s_wr         = 1'b1;
      s_wr_addr    = bus.mem_addr_o;
      s_wr_data    = bus.mem_wdata_o;
    end else if (bus.ct_pop_o) begin
      chk("pop_without_wr", 128'(bus.ct_pop_o), 128'(0));
    end
    s_pop = bus.ct_pop_o;
    if (bus.ad_push_o) begin
      if (exp_ad.size() != 0) chk("ad_data", 128'(bus.ad_o), 128'(exp_ad.pop_front()));
      n_push++;
      last_evt_cyc = cyc;
    end
    if (bus.pt_push_o) begin
      if (exp_pt.size() != 0) chk("pt_data", 128'(bus.pt_o), 128'(exp_pt.pop_front()));
      n_push++;
      last_evt_cyc = cyc;
      s_ptpush     = 1'b1;
      s_pt_data    = bus.pt_o;
    end
    if (bus.core_start_o) begin
      n_start++;
      start_cyc = cyc;
      started   = 1'b1;
    end
    if (done_o) begin
      n_done++;
      done_cyc = cyc;
    end
    if (bus.tag_valid_i) tag_cyc = cyc;
  endtask

  // Memory / FIFO side effects of the observed cycle, applied just after the edge.
  task automatic apply();
    u64_t c;
    if (s_wr) mem[s_wr_addr] = s_wr_data;
    if (s_pop && ct_q.size() != 0) void'(ct_q.pop_front());
    if (s_ptpush && gen_ct) begin
      c = s_pt_data ^ CT_KEY;
      ct_q.push_back(c);
      exp_wr_data.push_back(c);
      exp_wr_addr.push_back(cur_ct_base + 8'(gen_k));
      gen_k++;
    end
    bus.mem_rdata_i = s_rd ? mem[s_rd_addr] : rnd64();
    refresh_ct();
    s_rd = 1'b0; s_wr = 1'b0; s_pop = 1'b0; s_ptpush = 1'b0;
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    apply();
  endtask

  task automatic setup(input vec_t v);
    logic [7:0] a;
    u64_t d;
    ct_q.delete(); exp_ad.delete(); exp_pt.delete();
    exp_wr_data.delete(); exp_rd.delete(); exp_wr_addr.delete();
    n_rd = 0; n_start = 0; n_done = 0; wr_done = 0; n_push = 0; gen_k = 0; bp_viol = 0;
    start_cyc = -1; done_cyc = -1; tag_cyc = -1; last_evt_cyc = -1;
    last_rd_cyc = -10; first_rd_cyc = -1;
    started = 1'b0;
    cur_ad_n = v.ad_n; cur_pt_n = v.pt_n; cur_ct_base = v.ct_base;
    for (int i = 0; i < v.ad_n; i++) begin
      a = v.ad_base + 8'(i);
      mem[a] = rnd64();
      exp_rd.push_back(a);
      exp_ad.push_back(mem[a]);
    end
    for (int i = 0; i < v.pt_n; i++) begin
      a = v.pt_base + 8'(i);
      mem[a] = rnd64();
      exp_rd.push_back(a);
      exp_pt.push_back(mem[a]);
    end
    gen_ct = !v.preload;
    if (v.preload) begin
      for (int k = 0; k <= v.pt_n; k++) begin
        d = rnd64();
        ct_q.push_back(d);
        if (k < v.pt_n) begin
          exp_wr_data.push_back(d);
          exp_wr_addr.push_back(v.ct_base + 8'(k));
        end
      end
    end
    refresh_ct();
  endtask

  task automatic run_op(input vec_t v);
    bit tag_given;
    int extra;
    setup(v);
    ad_base_i  = v.ad_base;
    pt_base_i  = v.pt_base;
    ct_base_i  = v.ct_base;
    ad_words_i = DATA_AW'(v.ad_n);
    pt_words_i = DATA_AW'(v.pt_n);
    go_i = 1'b1;
    bus.ad_full_i   = (v.full_hold > 0);
    bus.tag_valid_i = 1'b0;
    go_cyc    = cyc + 1;
    tag_given = 1'b0;
    extra     = 0;
    for (int t = 0; t < 300 && extra < 3; t++) begin
      cycle();
      go_i = 1'b0;
      if (n_done > 0) extra++;
      if (started && v.full_hold > 0 && cyc - start_cyc == v.full_hold) bus.ad_full_i = 1'b0;
      bus.tag_valid_i = 1'b0;
      bus.tag_i       = {rnd64(), rnd64()};
      if (!tag_given && started &&
          (v.early_tag || (wr_done == v.pt_n && n_push == v.ad_n + v.pt_n &&
                           cyc >= last_evt_cyc + 2 && cyc >= start_cyc + 2))) begin
        bus.tag_valid_i = 1'b1;
        bus.tag_i       = v.tag;
        tag_given       = 1'b1;
      end
    end
    chk("start_pulses", 128'(n_start), 128'(1));
    chk("done_pulses", 128'(n_done), 128'(1));
    chk("go_to_start", 128'(start_cyc), 128'(go_cyc + 1));
    chk("rd_count", 128'(n_rd), 128'(v.exp_rd));
    chk("push_count", 128'(n_push), 128'(v.exp_rd));
    chk("wr_count", 128'(wr_done), 128'(v.exp_wr));
    chk("tag", tag_o, v.tag);
    chk("busy_after", 128'(busy_o), 128'(0));
    chk("exp_left", 128'(exp_rd.size() + exp_ad.size() + exp_pt.size() + exp_wr_addr.size()),
        128'(0));
    if (!v.early_tag) chk("done_after_tag", 128'(done_cyc), 128'(tag_cyc + 1));
    if (v.exp_rd > 0)
      chk("first_rd", 128'(first_rd_cyc),
          128'(start_cyc + 1 + v.full_hold + (v.preload ? v.pt_n : 0)));
    if (v.full_hold > 0) chk("bp_reads", 128'(bp_viol), 128'(0));
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_ctl"}, 128'({busy_o, done_o, bus.mem_rd_o, bus.mem_wr_o, bus.core_start_o,
                             bus.ad_push_o, bus.pt_push_o, bus.ct_pop_o}), 128'(0));
    chk({pfx, "_data"}, 128'({bus.mem_addr_o, bus.mem_wdata_o | bus.ad_o | bus.pt_o}), 128'(0));
    chk({pfx, "_tag"}, tag_o, 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    //        ad    pt    ct    adn ptn pre  early hold tag                                     rd wr
    vecs[0] = '{8'h00, 8'h10, 8'h20, 2, 3, 1'b0, 1'b0, 0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 5, 3};
    vecs[1] = '{8'h40, 8'h50, 8'h60, 0, 0, 1'b0, 1'b0, 0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0, 0};
    vecs[2] = '{8'h30, 8'hFE, 8'h80, 1, 3, 1'b0, 1'b0, 0, 128'hDEAD_BEEF_0000_0001_CAFE_F00D_0000_0002, 4, 3};
    vecs[3] = '{8'h08, 8'h18, 8'h28, 4, 3, 1'b1, 1'b0, 0, 128'hA0A0_B1B1_C2C2_D3D3_E4E4_F5F5_0606_1717, 7, 3};
    vecs[4] = '{8'hA0, 8'hB0, 8'hC0, 3, 1, 1'b0, 1'b0, 10, 128'h5A5A_5A5A_A5A5_A5A5_0F0F_0F0F_F0F0_F0F0, 4, 1};
    vecs[5] = '{8'h60, 8'h70, 8'hFD, 5, 4, 1'b0, 1'b1, 0, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 9, 4};
    vecs[6] = '{8'h88, 8'h90, 8'h98, 0, 2, 1'b0, 1'b0, 0, 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0, 2, 2};

    rst = 1'b1; go_i = 1'b0;
    ad_base_i = '0; pt_base_i = '0; ct_base_i = '0; ad_words_i = '0; pt_words_i = '0;
    bus.mem_rdata_i = '0; bus.core_ready_i = 1'b1; bus.tag_valid_i = 1'b0; bus.tag_i = '0;
    bus.ad_full_i = 1'b0; bus.pt_full_i = 1'b0; bus.ct_i = '0; bus.ct_empty_i = 1'b1;
    s_rd = 1'b0; s_wr = 1'b0; s_pop = 1'b0; s_ptpush = 1'b0;
    started = 1'b0; cur_pt_n = 0; cur_ad_n = 0; last_rd_cyc = -10;
    repeat (2) @(posedge clk);
    #1;
    bus.mem_rdata_i = rnd64();
    bus.ct_i        = rnd64();
    bus.ct_empty_i  = 1'b0;
    #1;
    chk_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    refresh_ct();

    foreach (vecs[i]) run_op(vecs[i]);

    // go_i must be ignored while the wrapper is not ready
    setup(vecs[1]);
    bus.core_ready_i = 1'b0;
    go_i = 1'b1;
    repeat (3) cycle();
    chk("not_ready_start", 128'(n_start), 128'(0));
    chk("not_ready_busy", 128'(busy_o), 128'(0));
    go_i = 1'b0;
    bus.core_ready_i = 1'b1;
    cycle();

    // Reset in the middle of a transfer, then restart right after release
    rv = '{8'h10, 8'h20, 8'h30, 4, 4, 1'b0, 1'b0, 0, 128'h0, 8, 4};
    setup(rv);
    ad_base_i = rv.ad_base; pt_base_i = rv.pt_base; ct_base_i = rv.ct_base;
    ad_words_i = DATA_AW'(rv.ad_n); pt_words_i = DATA_AW'(rv.pt_n);
    go_i = 1'b1;
    for (int t = 0; t < 40 && n_rd < 2; t++) begin
      cycle();
      go_i = 1'b0;
    end
    chk("midrst_reached_xfer", 128'(n_rd >= 2), 128'(1));
    rst = 1'b1;
    #2;
    chk_outputs_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
